opc_acc_cpu: RTL
================

// Module: opc_acc_cpu
// PURPOSE
//  Parametrised accumulator CPU, next generation of the team's minimal OPC core. Configurable data/address width and reset vector.
//  Adds ready-based memory wait states, subroutine call/return through a link register, carry set/clear and HALT.
//  Sits between the system bus and single-port memory; sole bus master.
// PARAMETERS
//  DW      8        data/accumulator width (>=8)
//  AW      12       address/PC/link width (<= 2*DW-4)
//  RST_VEC 0        PC value after reset (AW bits)
// PORTS
//  clk       in   1   clock, all state on rising edge
//  reset_b   in   1   reset, asynchronous, active-low
//  mem_din   in   DW  read data, sampled when mem_req && mem_ready && rnw
//  mem_ready in   1   memory completes current access this cycle
//  mem_req   out  1   access request; address/rnw/dout held stable until mem_ready
//  address   out  AW  access address
//  rnw       out  1   1=read, 0=write
//  mem_dout  out  DW  write data (=ACC when rnw=0, else 0)
//  halted    out  1   core stopped in HALT
// BEHAVIOUR
//  Reset: PC=RST_VEC, ACC=0, C=0, LINK=0, state=FETCH0, mem_req=1, rnw=1, address=RST_VEC, halted=0.
//  Instruction format: word0[DW-1:DW-4]=opcode, word0[DW-5:0]=operand high bits; word1=operand low DW bits.
//   OPR = {word0[DW-5:0],word1}[AW-1:0]. Even ALU opcodes are direct (operand=mem[OPR]); odd partners are immediate (operand=word1).
//  Opcodes: 0 AND / 1 ANDI: ACC&=op, C=0. 2 LDA / 3 LDAI: ACC=op.
//   4 STA: mem[OPR]=ACC. 5 JSR: LINK=PC (next instr), PC=OPR.
//   6 ADD / 7 ADDI: {C,ACC}=ACC+op+C, DW+1-bit result. 8 NOT / 9 NOTI: ACC=~op.
//   A JPC: PC=OPR if C. B RTS: PC=LINK. C JPZ: PC=OPR if ACC==0.
//   D SCF: C=OPR[0]. E JP: PC=OPR. F HALT.
//  FSM states FETCH0, FETCH1, RDMEM, EXEC, HALT. A memory state advances only on mem_ready; otherwise everything holds.
//   FETCH0: read PC; on ready latch opcode+high bits, PC+=1 -> FETCH1.
//   FETCH1: read PC; on ready latch word1, PC+=1. Next state: RDMEM if direct ALU op (0,2,6,8); HALT if F; else EXEC.
//   RDMEM: read OPR; on ready latch operand -> EXEC.
//   EXEC: STA drives write (rnw=0, address=OPR, dout=ACC) and waits for ready. All others take exactly 1 cycle, mem_req=0. -> FETCH0.
//   HALT: mem_req=0, halted=1; leaves only via reset.
//  Cycle latency with zero wait: immediate/jump/STA 3 cycles, direct ALU 4 cycles. Each wait cycle adds 1.
//  PC wraps modulo 2^AW, incl. fetch at all-ones -> 0. Taken jump at the last address overrides the increment.
//  Flags/ACC change only in EXEC. JPC/JPZ use the values before this EXEC.
//  JSR nesting: single LINK; a second JSR overwrites it. RTS without JSR returns to LINK (0 after reset).
//  Reset mid-access (incl. held write): immediate return to reset state; a partial write is not completed by the core.
//  mem_ready while mem_req=0 is ignored.
// STRUCTURE
//  Shared package opc_pkg: opcode localparams (OP_AND..OP_HALT), state encoding, is_direct(op) function.
//  One sub-module opc_acc_alu: combinational; op, ACC, C, operand -> next ACC, C.
//  Top module holds FSM, PC, LINK, IR and OR registers, and the bus mux.
// TESTING (DW=8, AW=12, RST_VEC=0, zero-wait memory unless stated)
//  Reset release: first cycle address=0x000, rnw=1, mem_req=1. LDAI 0x5A executes in 3 cycles -> ACC=0x5A, PC=0x002.
//  ADD with carry: ACC=0xF0, mem[0x123]=0x20, ADD 0x123 -> ACC=0x10, C=1. Following ADDI 0x01 -> ACC=0x12, C=0.
//  Wait states: mem_ready low for 3 cycles on every access. STA 0x3FF with ACC=0xA5 -> address/dout stable 4 cycles, mem[0x3FF]=0xA5 once.
//  Branches: ACC=0, JPZ 0x200 taken. C=0, JPC 0x300 not taken (PC=next). JSR 0x400 at 0x010 then RTS -> PC=0x012.
//  Wrap: RST_VEC=0xFFE, 2-word JP 0x005 fetched across 0xFFE/0xFFF -> PC=0x005. A 2-word LDAI at 0xFFE leaves PC=0x000.
//  HALT and reset: HALT -> halted=1, mem_req=0 indefinitely. Assert reset_b mid-STA wait -> reset state the same cycle, no further write.

Source files
------------

// File: rtl/opc_pkg.sv
// ---------------------------------------------------------------------------
// opc_pkg
// Shared definitions for the OPC accumulator core:
//   - 4-bit opcode values (OP_AND .. OP_HALT)
//   - control FSM state encoding (state_t)
//   - is_direct(): true for ALU opcodes whose operand is fetched from mem[OPR]
// No ports (package).
// ---------------------------------------------------------------------------
package opc_pkg;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_ANDI = 4'h1;
    localparam logic [3:0] OP_LDA  = 4'h2;
    localparam logic [3:0] OP_LDAI = 4'h3;
    localparam logic [3:0] OP_STA  = 4'h4;
    localparam logic [3:0] OP_JSR  = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_NOTI = 4'h9;
    localparam logic [3:0] OP_JPC  = 4'hA;
    localparam logic [3:0] OP_RTS  = 4'hB;
    localparam logic [3:0] OP_JPZ  = 4'hC;
    localparam logic [3:0] OP_SCF  = 4'hD;
    localparam logic [3:0] OP_JP   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH0,
        ST_FETCH1,
        ST_RDMEM,
        ST_EXEC,
        ST_HALT
    } state_t;

    // Direct ALU ops need an extra memory read of their operand.
    function automatic logic is_direct(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_LDA) || (op == OP_ADD) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/opc_acc_alu.sv
// ---------------------------------------------------------------------------
// opc_acc_alu
// Combinational accumulator ALU. Given the current opcode, accumulator,
// carry and operand it produces the accumulator/carry values that the core
// commits in its EXEC state. Opcodes with no ALU effect pass ACC and C through.
// Ports:
//   op       in  4   opcode
//   acc      in  DW  current accumulator
//   c        in  1   current carry
//   operand  in  DW  memory operand (direct) or word1 (immediate / SCF)
//   acc_next out DW  resulting accumulator
//   c_next   out 1   resulting carry
// ---------------------------------------------------------------------------
module opc_acc_alu
    import opc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] acc,
    input  logic          c,
    input  logic [DW-1:0] operand,
    output logic [DW-1:0] acc_next,
    output logic          c_next
);

    logic [DW:0] sum;

    always_comb begin
        // Add-with-carry: carry-in is the current C, carry-out lands in bit DW.
        sum      = {1'b0, acc} + {1'b0, operand} + {{DW{1'b0}}, c};
        acc_next = acc;
        c_next   = c;
        case (op)
            OP_AND, OP_ANDI: begin
                acc_next = acc & operand;
                c_next   = 1'b0;
            end
            OP_LDA, OP_LDAI: acc_next = operand;
            OP_ADD, OP_ADDI: {c_next, acc_next} = sum;
            OP_NOT, OP_NOTI: acc_next = ~operand;
            // SCF carries its flag value in OPR[0], which is word1[0].
            OP_SCF:          c_next = operand[0];
            default:         ;
        endcase
    end

endmodule

// File: rtl/opc_acc_cpu.sv
// ---------------------------------------------------------------------------
// opc_acc_cpu
// Two-word-instruction accumulator CPU; sole master of a single-port memory.
// Holds the control FSM, PC, LINK, instruction register (word0), operand
// register (word1, replaced by mem[OPR] for direct ALU ops) and the bus mux.
// Parameters: DW data width (>=8), AW address width (<= 2*DW-4),
//             RST_VEC PC after reset.
// Ports:
//   clk       in  1   clock, rising edge
//   reset_b   in  1   asynchronous active-low reset
//   mem_din   in  DW  read data, taken when mem_req && mem_ready && rnw
//   mem_ready in  1   memory completes the current access this cycle
//   mem_req   out 1   access request, address/rnw/dout held until ready
//   address   out AW  access address
//   rnw       out 1   1 = read, 0 = write
//   mem_dout  out DW  write data (ACC during a write, else 0)
//   halted    out 1   core has executed HALT
// ---------------------------------------------------------------------------
module opc_acc_cpu
    import opc_pkg::*;
#(
    parameter int            DW      = 8,
    parameter int            AW      = 12,
    parameter logic [AW-1:0] RST_VEC = '0
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic [DW-1:0] mem_din,
    input  logic          mem_ready,
    output logic          mem_req,
    output logic [AW-1:0] address,
    output logic          rnw,
    output logic [DW-1:0] mem_dout,
    output logic          halted
);

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] link_q, link_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] or_q, or_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          c_q, c_d;

    logic [3:0]      opcode;
    logic [2*DW-5:0] opr_full;
    logic [AW-1:0]   opr;
    logic [DW-1:0]   alu_acc;
    logic            alu_c;

    assign opcode   = ir_q[DW-1:DW-4];
    assign opr_full = {ir_q[DW-5:0], or_q};
    assign opr      = opr_full[AW-1:0];

    opc_acc_alu #(
        .DW (DW)
    ) u_alu (
        .op       (opcode),
        .acc      (acc_q),
        .c        (c_q),
        .operand  (or_q),
        .acc_next (alu_acc),
        .c_next   (alu_c)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_FETCH0;
            pc_q    <= RST_VEC;
            link_q  <= '0;
            ir_q    <= '0;
            or_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            link_q  <= link_d;
            ir_q    <= ir_d;
            or_q    <= or_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
        end
    end

    // Next-state and bus mux. Memory states hold everything until mem_ready,
    // and mem_ready is only looked at in states that drive mem_req.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        link_d   = link_q;
        ir_d     = ir_q;
        or_d     = or_q;
        acc_d    = acc_q;
        c_d      = c_q;
        mem_req  = 1'b0;
        rnw      = 1'b1;
        address  = pc_q;
        mem_dout = '0;

        case (state_q)
            ST_FETCH0: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_din;
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_FETCH1;
                end
            end

            ST_FETCH1: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    or_d = mem_din;
                    pc_d = pc_q + PC_ONE;
                    if (is_direct(opcode)) begin
                        state_d = ST_RDMEM;
                    end else if (opcode == OP_HALT) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_RDMEM: begin
                // OPR is formed from word1 here; it is no longer needed once
                // the operand replaces word1 in the operand register.
                mem_req = 1'b1;
                address = opr;
                if (mem_ready) begin
                    or_d    = mem_din;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (opcode == OP_STA) begin
                    mem_req  = 1'b1;
                    rnw      = 1'b0;
                    address  = opr;
                    mem_dout = acc_q;
                    if (mem_ready) begin
                        state_d = ST_FETCH0;
                    end
                end else begin
                    acc_d   = alu_acc;
                    c_d     = alu_c;
                    state_d = ST_FETCH0;
                    // Conditions use the pre-EXEC flag/ACC values.
                    case (opcode)
                        OP_JSR: begin
                            link_d = pc_q;
                            pc_d   = opr;
                        end
                        OP_JPC:  if (c_q) pc_d = opr;
                        OP_RTS:  pc_d = link_q;
                        OP_JPZ:  if (acc_q == '0) pc_d = opr;
                        OP_JP:   pc_d = opr;
                        default: ;
                    endcase
                end
            end

            ST_HALT: ;

            default: state_d = ST_FETCH0;
        endcase
    end

    assign halted = (state_q == ST_HALT);

endmodule
